// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program run sequencer.
// Holds sequencer state and status encodings.
package program_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ACK  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_BADSEL  = 2'b10
    } seq_status_t;

endpackage

// File: rtl/program_sequencer_watchdog.sv
// Saturating run-cycle counter with limit comparison.
// expired flags that the increment taken this cycle lands on the limit.
module run_watchdog
    import program_sequencer_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          expired
);

    logic [CW-1:0] count_nxt;

    assign count_nxt = (&count) ? count : count + CW'(1);
    assign expired   = enable && (limit != '0) && (count_nxt == limit);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Run controller: accepts a program request, holds the core in reset
// while presenting the entry PC, runs it, and returns a status ack.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                     T           = 10,
    parameter int                     NUM_PROGS   = 4,
    parameter int                     SELW        = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    parameter logic [NUM_PROGS*T-1:0] ENTRY_TABLE = '0,
    parameter int                     CW          = 16,
    parameter int unsigned            MAX_CYCLES  = 16'hFFFF
) (
    input  logic            clk,
    input  logic            init_n,
    input  logic            req,
    input  logic [SELW-1:0] prog_sel,
    output logic            ack,
    output logic [1:0]      status,
    output logic            busy,
    output logic            core_rst,
    output logic            core_start,
    output logic [T-1:0]    entry_pc,
    input  logic            core_done,
    output logic [CW-1:0]   cycle_count
);

    seq_state_t  state;
    seq_status_t status_q;
    logic [T-1:0] entry_sel;
    logic         sel_bad;
    logic         accept;
    logic         wd_clear;
    logic         wd_enable;
    logic         wd_expired;

    assign sel_bad = int'(prog_sel) >= NUM_PROGS;
    assign accept  = (state == IDLE) && req && !sel_bad;

    always_comb begin
        entry_sel = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (int'(prog_sel) == i) begin
                entry_sel = ENTRY_TABLE[i*T +: T];
            end
        end
    end

    // Done in RUN freezes the counter, so the done cycle is never counted.
    assign wd_clear  = !init_n || accept;
    assign wd_enable = (state == RUN) && !core_done;

    run_watchdog #(
        .CW(CW)
    ) u_watchdog (
        .clk    (clk),
        .clear  (wd_clear),
        .enable (wd_enable),
        .limit  (CW'(MAX_CYCLES)),
        .count  (cycle_count),
        .expired(wd_expired)
    );

    assign status = status_q;

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state      <= IDLE;
            ack        <= 1'b0;
            status_q   <= ST_OK;
            busy       <= 1'b0;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
            entry_pc   <= '0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req && sel_bad) begin
                        state    <= ACK;
                        ack      <= 1'b1;
                        status_q <= ST_BADSEL;
                    end else if (req) begin
                        state    <= LOAD;
                        entry_pc <= entry_sel;
                        status_q <= ST_OK;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= RUN;
                    core_rst   <= 1'b0;
                    core_start <= 1'b1;
                end
                RUN: begin
                    if (core_done || wd_expired) begin
                        state    <= ACK;
                        ack      <= 1'b1;
                        busy     <= 1'b0;
                        core_rst <= 1'b1;
                        status_q <= core_done ? ST_OK : ST_TIMEOUT;
                    end
                end
                ACK: begin
                    if (!req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: two instances (watchdog off / limit 20)
// share stimulus and are checked every cycle against a run-level model.
module tb_program_sequencer;

    localparam int NPROG = 3;
    localparam logic [29:0] TABLE = {10'h040, 10'h123, 10'h010};

    logic       clk;
    logic       init_n;
    logic       req;
    logic [1:0] sel;
    logic       done;

    logic        ack_o   [2];
    logic [1:0]  st_o    [2];
    logic        busy_o  [2];
    logic        rst_o   [2];
    logic        start_o [2];
    logic [9:0]  pc_o    [2];
    logic [15:0] cnt_o   [2];

    program_sequencer #(
        .T(10), .NUM_PROGS(NPROG), .ENTRY_TABLE(TABLE),
        .CW(16), .MAX_CYCLES(0)
    ) u_a (
        .clk(clk), .init_n(init_n), .req(req), .prog_sel(sel),
        .ack(ack_o[0]), .status(st_o[0]), .busy(busy_o[0]),
        .core_rst(rst_o[0]), .core_start(start_o[0]),
        .entry_pc(pc_o[0]), .core_done(done), .cycle_count(cnt_o[0])
    );

    program_sequencer #(
        .T(10), .NUM_PROGS(NPROG), .ENTRY_TABLE(TABLE),
        .CW(16), .MAX_CYCLES(20)
    ) u_b (
        .clk(clk), .init_n(init_n), .req(req), .prog_sel(sel),
        .ack(ack_o[1]), .status(st_o[1]), .busy(busy_o[1]),
        .core_rst(rst_o[1]), .core_start(start_o[1]),
        .entry_pc(pc_o[1]), .core_done(done), .cycle_count(cnt_o[1])
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;
    int starts [2] = '{0, 0};

    // Model: age = cycles since acceptance (-1 when idle), fin = acking.
    int         lim   [2] = '{0, 20};
    int         age   [2] = '{-1, -1};
    bit         fin   [2] = '{0, 0};
    int         mst   [2] = '{0, 0};
    int         mcnt  [2] = '{0, 0};
    int         mpc   [2] = '{0, 0};
    int         entry [3] = '{'h010, 'h123, 'h040};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int k);
        if (!init_n) begin
            age[k] = -1; fin[k] = 0; mst[k] = 0; mcnt[k] = 0; mpc[k] = 0;
        end else if (fin[k]) begin
            if (!req) begin
                fin[k] = 0;
                age[k] = -1;
            end
        end else if (age[k] < 0) begin
            if (req && int'(sel) >= NPROG) begin
                fin[k] = 1; mst[k] = 2;
            end else if (req) begin
                age[k] = 0; mpc[k] = entry[sel]; mcnt[k] = 0; mst[k] = 0;
            end
        end else if (age[k] == 0) begin
            age[k] = 1;
        end else if (done) begin
            fin[k] = 1; mst[k] = 0;
        end else begin
            if (mcnt[k] < 65535) mcnt[k]++;
            age[k]++;
            if (lim[k] != 0 && mcnt[k] == lim[k]) begin
                fin[k] = 1; mst[k] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit run;
                run = !fin[k] && age[k] >= 1;
                chk($sformatf("u%0d.ack", k), int'(ack_o[k]), int'(fin[k]));
                chk($sformatf("u%0d.status", k), int'(st_o[k]), mst[k]);
                chk($sformatf("u%0d.busy", k), int'(busy_o[k]),
                    int'(!fin[k] && age[k] >= 0));
                chk($sformatf("u%0d.core_rst", k), int'(rst_o[k]), int'(!run));
                chk($sformatf("u%0d.core_start", k), int'(start_o[k]),
                    int'(run && age[k] == 1));
                chk($sformatf("u%0d.entry_pc", k), int'(pc_o[k]), mpc[k]);
                chk($sformatf("u%0d.cycle_count", k), int'(cnt_o[k]), mcnt[k]);
                if (start_o[k]) starts[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        init_n = 0; req = 0; sel = 0; done = 0;
        tick();
        chk_en = 1;
        tick();
        chk("reset.ack", int'(ack_o[0]), 0);
        chk("reset.busy", int'(busy_o[0]), 0);
        chk("reset.core_rst", int'(rst_o[0]), 1);
        chk("reset.cycle_count", int'(cnt_o[0]), 0);
        init_n = 1;
        tick();

        // done pulses while idle do nothing
        done = 1;
        repeat (3) tick();
        done = 0;
        chk("idle_done.ack", int'(ack_o[0]), 0);

        // normal run of 37 cycles; u_b times out at 20 meanwhile
        sel = 2; req = 1;
        tick();
        chk("load.entry_pc", int'(pc_o[0]), 'h040);
        chk("load.core_rst", int'(rst_o[0]), 1);
        chk("load.busy", int'(busy_o[0]), 1);
        repeat (38) tick();
        done = 1;
        tick();
        done = 0;
        chk("run.ack", int'(ack_o[0]), 1);
        chk("run.status", int'(st_o[0]), 0);
        chk("run.cycle_count", int'(cnt_o[0]), 37);
        chk("run.start_pulses", starts[0], 1);
        chk("wd.ack", int'(ack_o[1]), 1);
        chk("wd.status", int'(st_o[1]), 1);
        chk("wd.core_rst", int'(rst_o[1]), 1);
        chk("wd.cycle_count", int'(cnt_o[1]), 20);

        // req held high: no second run
        repeat (5) tick();
        chk("hold.ack", int'(ack_o[0]), 1);
        chk("hold.busy", int'(busy_o[0]), 0);
        req = 0;
        tick();
        chk("drop.ack", int'(ack_o[0]), 0);

        // bad select
        sel = 3; req = 1;
        tick();
        chk("badsel.ack", int'(ack_o[0]), 1);
        chk("badsel.status", int'(st_o[0]), 2);
        chk("badsel.core_rst", int'(rst_o[0]), 1);
        chk("badsel.start_pulses", starts[0], 1);
        req = 0;
        tick();

        // req dropped during the run
        sel = 1; req = 1;
        tick();
        req = 0;
        repeat (11) tick();
        done = 1;
        tick();
        done = 0;
        chk("middrop.ack", int'(ack_o[0]), 1);
        chk("middrop.cycle_count", int'(cnt_o[0]), 10);
        chk("middrop.entry_pc", int'(pc_o[0]), 'h123);
        tick();
        chk("middrop.ack_clear", int'(ack_o[0]), 0);

        // done coincides with the 20th count on u_b: done wins
        sel = 0; req = 1;
        repeat (21) tick();
        done = 1;
        tick();
        done = 0;
        chk("tie.status", int'(st_o[1]), 0);
        chk("tie.cycle_count", int'(cnt_o[1]), 19);
        req = 0;
        tick();

        // reset mid-run, then a normal run
        sel = 2; req = 1;
        repeat (6) tick();
        init_n = 0; req = 0;
        tick();
        chk("midrst.ack", int'(ack_o[0]), 0);
        chk("midrst.core_rst", int'(rst_o[0]), 1);
        chk("midrst.cycle_count", int'(cnt_o[0]), 0);
        init_n = 1;
        sel = 0; req = 1;
        repeat (7) tick();
        done = 1;
        tick();
        done = 0;
        chk("after_rst.ack", int'(ack_o[0]), 1);
        chk("after_rst.cycle_count", int'(cnt_o[0]), 5);
        chk("after_rst.entry_pc", int'(pc_o[0]), 'h010);
        req = 0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Run controller between the external req/ack interface and the processor core, generalising the single-program, single-handshake top level.
- Accepts a request carrying a program selector, holds the core in reset while it presents the selected entry PC, and releases it to run.
- Counts execution cycles, enforces a watchdog, and returns a four-phase ack with a status code.
- Instantiated once per core, above InstFetch/RegFile/DataMem.

Parameters:
- T, 10, program-counter width
- NUM_PROGS, 4, number of selectable programs (entry points), ≥1
- SELW, $clog2(NUM_PROGS) min 1, prog_sel width
- ENTRY_TABLE, all-zero, packed NUM_PROGS*T vector; entry i at bits [i*T +: T]
- CW, 16, cycle counter width
- MAX_CYCLES, 16'hFFFF, watchdog limit in core cycles; 0 disables watchdog

Ports:
- clk  in  1  system clock
- init_n  in  1  synchronous active-low reset
- req  in  1  run request, four-phase
- prog_sel  in  SELW  program index, sampled when req is accepted
- ack  out  1  run complete; held until req drops
- status  out  2  result code, valid while ack=1: 00 OK, 01 TIMEOUT, 10 BADSEL
- busy  out  1  high from request acceptance until ack asserts
- core_rst  out  1  active-high reset to core (InstFetch/RegFile Reset)
- core_start  out  1  one-cycle pulse into RegFile start
- entry_pc  out  T  start PC for InstFetch load
- core_done  in  1  core Done_out
- cycle_count  out  CW  cycles spent in RUN for the current/last run

Behaviour:
- Reset (init_n=0 at a clk edge):
  - State goes to IDLE.
  - ack=0, status=00, busy=0, core_rst=1, core_start=0, entry_pc=0, cycle_count=0.
  - Reset mid-run aborts immediately; no ack is produced.
- States: IDLE, LOAD, RUN, ACK.
- IDLE:
  - core_rst=1.
  - On req=1, latch prog_sel.
  - If prog_sel ≥ NUM_PROGS: go to ACK with status=10 and skip the core.
  - Otherwise: entry_pc ← ENTRY_TABLE[prog_sel], cycle_count ← 0, busy ← 1, go to LOAD.
- LOAD:
  - Exactly one cycle; core_rst=1, entry_pc stable.
  - Next cycle: core_rst=0, core_start=1 (single cycle), go to RUN.
- RUN:
  - core_rst=0.
  - cycle_count increments every cycle and saturates at all-ones.
  - core_done=1 → go to ACK with status=00; the done cycle is not counted.
  - If MAX_CYCLES≠0 and cycle_count reaches MAX_CYCLES with core_done=0 → go to ACK with status=01, core_rst=1.
  - If done and timeout occur in the same cycle, done wins (status 00).
- ACK:
  - ack=1, busy=0, core_rst=1; status and cycle_count held.
  - When req=0: ack←0, go to IDLE.
  - A new request is accepted only in IDLE, so req must drop and rise again.
- Latency:
  - req rising in IDLE → busy=1 next cycle.
  - First core instruction executes 2 cycles after acceptance.
  - BADSEL: ack asserts 1 cycle after acceptance.
- req dropping during LOAD/RUN is ignored; the run completes and ack asserts, then clears once req is seen low.
- core_done asserted in IDLE/LOAD/ACK is ignored.
- entry_pc and status change only on state transitions, never combinationally from inputs.

Decomposition:
- Shared package (add to Definitions): seq_state_t enum {IDLE, LOAD, RUN, ACK}; seq_status_t enum {ST_OK=2'b00, ST_TIMEOUT=2'b01, ST_BADSEL=2'b10}.
- One sub-module, run_watchdog (parameter CW): clear, enable, limit, count output, expired flag, saturating. It holds the counter and comparison; the FSM stays in program_sequencer.

Test Plan:
- Reset then idle: init_n low 2 cycles → ack=0, busy=0, core_rst=1, cycle_count=0; core_done pulses in IDLE produce no ack.
- Normal run: ENTRY_TABLE entry 2 = 10'h040, req=1 with prog_sel=2, core_done after 37 RUN cycles:
  - Expect entry_pc=0x040 during LOAD and one core_start pulse.
  - Expect ack=1 with status=00 and cycle_count=37.
  - Drop req → ack=0 next cycle.
- Watchdog: MAX_CYCLES=20, core_done never asserted → after 20 RUN cycles ack=1, status=01, core_rst=1, cycle_count=20.
- Bad select: NUM_PROGS=3, prog_sel=3 → ack=1 one cycle after acceptance, status=10, core_rst stays 1, no core_start.
- Handshake rules:
  - req held high after ack → no second run.
  - req dropped mid-RUN → run completes and ack pulses for 1 cycle.
  - done and timeout in the same cycle → status=00.
- Reset mid-run: init_n=0 during RUN → next cycle IDLE, core_rst=1, ack=0, cycle_count=0; a subsequent request with prog_sel=0 runs normally.
